// File: rtl/button_event_encoder.sv
// Six-button calculator front-end: synchronize, debounce and edge-detect each key,
// priority-encode presses into event codes and queue them behind a valid/ready port.
module button_event_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [5:0]                    btn_raw,
   output logic                          ev_valid,
   output logic [2:0]                    ev_code,
   input  logic                          ev_ready,
   output logic [$clog2(FIFO_DEPTH):0]   ev_count,
   output logic                          overflow,
   output logic                          collision,
   input  logic                          flag_clr
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);
   localparam logic [2:0]       CODE_CLEAR = 3'd5;

   logic [5:0]      sync1;
   logic [5:0]      sync2;
   logic [5:0]      stable;
   logic [5:0]      stable_d;
   logic [DB_W-1:0] db_cnt [6];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1    <= '0;
         sync2    <= '0;
         stable   <= '0;
         stable_d <= '0;
         for (int i = 0; i < 6; i++) db_cnt[i] <= '0;
      end else begin
         sync1    <= btn_raw;
         sync2    <= sync1;
         stable_d <= stable;
         for (int i = 0; i < 6; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // Rising edge of the debounced level; releases are deliberately ignored.
   logic [5:0] press;
   logic       win_valid;
   logic [2:0] win_code;
   logic       multi_press;

   assign press       = stable & ~stable_d;
   assign multi_press = (press & (press - 6'd1)) != 6'd0;

   // Ascending scan: the highest index (CLEAR) overrides lower ones.
   always_comb begin
      win_valid = 1'b0;
      win_code  = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (press[i]) begin
            win_valid = 1'b1;
            win_code  = 3'(i);
         end
      end
   end

   logic [2:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             full;
   logic             pop;

   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic [PTR_W-1:0] wr_ptr_n;
   logic [PTR_W-1:0] rd_ptr_n;
   logic [CNT_W-1:0] count_n;
   logic             ovf_set;

   assign full = (count == CNT_FULL);
   assign pop  = ev_valid & ev_ready;

   always_comb begin
      wr_en    = 1'b0;
      wr_addr  = wr_ptr;
      wr_ptr_n = wr_ptr;
      rd_ptr_n = rd_ptr;
      count_n  = count;
      ovf_set  = 1'b0;
      if (win_valid && win_code == CODE_CLEAR) begin
         // CLEAR flushes everything, including a head being popped this cycle.
         wr_en    = 1'b1;
         wr_addr  = '0;
         wr_ptr_n = PTR_W'(1);
         rd_ptr_n = '0;
         count_n  = CNT_W'(1);
      end else begin
         if (pop) begin
            rd_ptr_n = rd_ptr + PTR_W'(1);
            count_n  = count - CNT_W'(1);
         end
         if (win_valid) begin
            if (!full || pop) begin
               wr_en    = 1'b1;
               wr_ptr_n = wr_ptr + PTR_W'(1);
               count_n  = pop ? count : count + CNT_W'(1);
            end else begin
               ovf_set = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 3'd0;
      end else begin
         wr_ptr <= wr_ptr_n;
         rd_ptr <= rd_ptr_n;
         count  <= count_n;
         if (wr_en) mem[wr_addr] <= win_code;
      end
   end

   // Sticky flags: a same-cycle set beats flag_clr.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow  <= 1'b0;
         collision <= 1'b0;
      end else begin
         if (ovf_set)       overflow <= 1'b1;
         else if (flag_clr) overflow <= 1'b0;
         if (multi_press)   collision <= 1'b1;
         else if (flag_clr) collision <= 1'b0;
      end
   end

   assign ev_valid = (count != '0);
   assign ev_code  = ev_valid ? mem[rd_ptr] : 3'd0;
   assign ev_count = count;

endmodule

// File: tb/tb_button_event_encoder.sv
// Directed bench for button_event_encoder: expected codes queue on stimulus,
// a negedge monitor compares every accepted handshake against the queue head.
module tb_button_event_encoder;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] btn_raw = '0;
   logic       ev_ready = 1'b0;
   logic       flag_clr = 1'b0;
   logic       ev_valid;
   logic [2:0] ev_code;
   logic [2:0] ev_count;
   logic       overflow;
   logic       collision;

   logic [2:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   button_event_encoder #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .btn_raw(btn_raw),
      .ev_valid(ev_valid), .ev_code(ev_code), .ev_ready(ev_ready),
      .ev_count(ev_count), .overflow(overflow), .collision(collision),
      .flag_clr(flag_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout act=running req=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s act=%0d req=%0d", name, act, req);
      end
   endtask

   // Monitor: every accepted handshake must match the oldest expected code.
   always @(negedge clk) begin
      if (!rst && ev_valid && ev_ready) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected act=%0d req=none", ev_code);
         end else begin
            logic [2:0] e;
            e = exp_q.pop_front();
            if (ev_code !== e) begin
               n_err++;
               $display("FAIL pop_code act=%0d req=%0d", ev_code, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press_key(input int idx, input bit enq);
      btn_raw[idx] = 1'b1;
      if (enq) exp_q.push_back(3'(idx));
      repeat (DB + 3) tick();
      btn_raw[idx] = 1'b0;
      repeat (DB + 3) tick();
   endtask

   task automatic drain();
      ev_ready = 1'b1;
      for (int i = 0; i < 12 && ev_valid; i++) tick();
      ev_ready = 1'b0;
      check("drain_valid", ev_valid, 0);
      check("drain_exp_left", exp_q.size(), 0);
   endtask

   task automatic pulse_clr();
      flag_clr = 1'b1;
      tick();
      flag_clr = 1'b0;
   endtask

   initial begin
      repeat (2) tick();
      rst = 1'b0;
      check("rst_valid", ev_valid, 0);
      check("rst_code", ev_code, 0);
      check("rst_count", ev_count, 0);
      check("rst_overflow", overflow, 0);
      check("rst_collision", collision, 0);

      // Ready while empty is ignored.
      ev_ready = 1'b1;
      repeat (2) tick();
      ev_ready = 1'b0;
      check("empty_ready_count", ev_count, 0);

      // Clean press of OR with exact latency.
      btn_raw[2] = 1'b1;
      exp_q.push_back(3'd2);
      repeat (DB + 2) tick();
      check("clean_before_valid", ev_valid, 0);
      tick();
      check("clean_valid", ev_valid, 1);
      check("clean_code", ev_code, 2);
      check("clean_count", ev_count, 1);
      repeat (13) tick();
      check("clean_held_count", ev_count, 1);
      btn_raw[2] = 1'b0;
      repeat (10) tick();
      check("clean_release_count", ev_count, 1);
      drain();

      // Bounce on ONE yields nothing; a steady hold yields one event.
      btn_raw[0] = 1'b1; tick();
      btn_raw[0] = 1'b0; tick();
      btn_raw[0] = 1'b1; tick();
      btn_raw[0] = 1'b0;
      repeat (10) tick();
      check("bounce_count", ev_count, 0);
      btn_raw[0] = 1'b1;
      exp_q.push_back(3'd0);
      repeat (DB + 2) tick();
      check("bounce_hold_early", ev_count, 0);
      tick();
      check("bounce_hold_valid", ev_valid, 1);
      check("bounce_hold_code", ev_code, 0);
      btn_raw[0] = 1'b0;
      repeat (DB + 3) tick();
      drain();

      // Ordering and overflow under backpressure.
      press_key(0, 1);
      press_key(1, 1);
      press_key(3, 1);
      press_key(4, 1);
      check("order_full_count", ev_count, 4);
      check("order_no_overflow", overflow, 0);
      press_key(2, 0);
      check("ovf_count", ev_count, 4);
      check("ovf_flag", overflow, 1);
      drain();
      pulse_clr();
      check("ovf_cleared", overflow, 0);

      // Full FIFO with a same-cycle pop accepts the new press at the tail.
      press_key(0, 1);
      press_key(1, 1);
      press_key(3, 1);
      press_key(4, 1);
      btn_raw[2] = 1'b1;
      exp_q.push_back(3'd2);
      repeat (DB + 2) tick();
      ev_ready = 1'b1;
      tick();
      ev_ready = 1'b0;
      check("fullpop_count", ev_count, 4);
      check("fullpop_overflow", overflow, 0);
      btn_raw[2] = 1'b0;
      repeat (DB + 3) tick();
      drain();

      // CLEAR and ZERO on the same edge with three entries queued.
      press_key(0, 1);
      press_key(1, 1);
      press_key(3, 1);
      check("pre_clear_count", ev_count, 3);
      btn_raw[5] = 1'b1;
      btn_raw[1] = 1'b1;
      exp_q.delete();
      exp_q.push_back(3'd5);
      repeat (DB + 3) tick();
      check("clear_collision", collision, 1);
      check("clear_count", ev_count, 1);
      check("clear_code", ev_code, 5);
      btn_raw[5] = 1'b0;
      btn_raw[1] = 1'b0;
      repeat (DB + 3) tick();
      pulse_clr();
      check("collision_cleared", collision, 0);
      drain();

      // Asynchronous reset mid-cycle with two entries and a collision flag.
      btn_raw[0] = 1'b1;
      btn_raw[1] = 1'b1;
      repeat (DB + 3) tick();
      btn_raw[0] = 1'b0;
      btn_raw[1] = 1'b0;
      repeat (DB + 3) tick();
      press_key(3, 0);
      check("pre_rst_count", ev_count, 2);
      check("pre_rst_collision", collision, 1);
      #3;
      rst = 1'b1;
      #1;
      check("arst_valid", ev_valid, 0);
      check("arst_count", ev_count, 0);
      check("arst_collision", collision, 0);
      check("arst_overflow", overflow, 0);
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
      repeat (10) tick();
      check("post_rst_count", ev_count, 0);

      check("final_exp_left", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/button_event_encoder.md
# button_event_encoder

Front-end that turns the six raw calculator push-buttons (1, 0, OR, XOR, =, CLEAR) into a clean, ordered stream of key events for the calculator core. Each button is synchronized, debounced and edge-detected. Presses are priority-encoded into a 3-bit event code and queued in a small FIFO. The core drains the FIFO through a valid/ready handshake, so it never sees bounce, held keys or lost ordering.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a level change is accepted (>=1)
- FIFO_DEPTH, 4: event queue depth, power of two, >=2
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous and active-high
- btn_raw  in  6  raw buttons, 1 = pressed: [0] ONE, [1] ZERO, [2] OR, [3] XOR, [4] EQUALS, [5] CLEAR
- ev_valid  out  1  FIFO head holds an event
- ev_code  out  3  head event: 0 ONE, 1 ZERO, 2 OR, 3 XOR, 4 EQUALS, 5 CLEAR; 0 when empty
- ev_ready  in  1  consumer accepts head this cycle
- ev_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- collision  out  1  sticky: two or more presses were detected in the same cycle
- flag_clr  in  1  clears overflow and collision on the next edge

## Operation
- Per button: 2-flop synchronizer (sync1, sync2), a debounced level stable (reset 0), and a counter.
- Debounce: on each edge where sync2 != stable, the counter increments.
  - When the counter is at DEBOUNCE_CYCLES-1 and the mismatch persists, stable <= sync2 and the counter <= 0.
  - Any edge with sync2 == stable resets the counter to 0. Bounce shorter than DEBOUNCE_CYCLES therefore produces nothing.
- Press = stable rises 0->1 (combinational, one cycle). Releases generate no event. A held button generates exactly one event.
- Priority when several presses occur in one cycle: CLEAR > EQUALS > XOR > OR > ZERO > ONE.
  - Only the winner is enqueued. The others are discarded and collision is set.
- Enqueue rules for the winner:
  - CLEAR: flush the FIFO and write CLEAR as the sole entry, so count = 1. This holds regardless of full state and regardless of a same-cycle pop.
  - Other code, not full: write at the tail.
  - Other code, full, with a pop in the same cycle: write accepted and count unchanged.
  - Other code, full, no pop: dropped, overflow set, FIFO unchanged.
- Pop: ev_valid && ev_ready advances the head. ev_ready while empty is ignored.
- ev_valid = (count != 0). ev_code is the head entry (combinational from storage), forced to 0 when empty.
- Pointers wrap modulo FIFO_DEPTH. Count saturates neither up nor down; the rules above keep it in 0..FIFO_DEPTH.
- flag_clr clears both sticky flags. A set condition in the same cycle wins, so the flag stays 1.

## Timing
- Reset (async assert, synchronous-to-clk deassert by the system) forces:
  - ev_valid=0, ev_code=0, ev_count=0, overflow=0, collision=0
  - all sync/stable/counter state = 0 and FIFO pointers = 0
- A button held through reset release produces one press after normal debounce latency.
- Press latency: raw first sampled high at edge 0 and held.
  - sync2=1 after edge 1.
  - stable=1 after edge DEBOUNCE_CYCLES+1.
  - Entry written and ev_valid=1 after edge DEBOUNCE_CYCLES+2 (6 with the default).
- Pop: head advances on the edge where ev_valid && ev_ready. The new head or ev_valid=0 is visible right after that edge.
- Handshake: ev_code is stable while ev_valid=1 && ev_ready=0, except when a CLEAR flush replaces the head.
- Reset mid-operation discards queued events, in-flight debounce state and flags immediately.

## Test plan
- Clean press: after reset, hold btn_raw[2] for 20 cycles -> ev_valid rises after edge 6 with ev_code=2; exactly one event; release produces none.
- Bounce: toggle btn_raw[0] 1,0,1,0 on successive cycles, then hold 0 -> no event, ev_count stays 0. Then hold 1 -> ev_code=0 after 6 edges.
- Ordering/backpressure: ev_ready=0; press ONE, ZERO, XOR, EQUALS in turn -> ev_count=4. Press OR -> overflow=1, count 4. Then ev_ready=1 -> codes popped in order 0,1,3,4.
- Full with pop: FIFO full, ev_ready=1 in the same cycle that an OR press is enqueued -> count stays 4, overflow stays 0, OR is at the tail.
- Collision/CLEAR: raise btn_raw[5] and btn_raw[1] on the same edge with 3 entries queued -> collision=1, ev_count=1, ev_code=5. flag_clr -> collision=0.
- Async reset: assert rst mid-cycle with 2 entries queued -> ev_valid, ev_count and flags go to 0 without waiting for a clock edge.
